// File: rtl/dsmod_interp_buf.sv
// One-entry valid/ready input buffer for low-rate sample feeders.
// Holds a single sample until the consumer strobes consume_i.
module dsmod_interp_buf #(
  parameter int n = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [n-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         consume_i,
  output logic [n-1:0] data_o,
  output logic         full_o
);

  logic [n-1:0] data_q, data_d;
  logic         full_q, full_d;
  logic         accept;

  assign ready_o = !full_q;
  assign accept  = valid_i && !full_q;
  assign data_o  = data_q;
  assign full_o  = full_q;

  // Accept only when empty and consume only when full, so both never coincide.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (accept) begin
      data_d = data_i;
      full_d = 1'b1;
    end else if (consume_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/dsmod_interp.sv
// Linear interpolator feeding the delta-sigma modulator: ramps between
// consecutive low-rate input samples over R = 2^k clocks, one output per clock.
module dsmod_interp #(
  parameter int n = 16,
  parameter int k = 6
) (
  input  logic                clk,
  input  logic                clr,
  input  logic signed [n-1:0] in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [n-1:0] out,
  output logic                underrun
);

  typedef enum logic {IDLE, RUN} state_e;
  localparam int R = 1 << k;

  state_e                state_q, state_d;
  logic        [k-1:0]   ph_q, ph_d;
  logic signed [n-1:0]   prev_q, prev_d;
  logic signed [n-1:0]   cur_q, cur_d;
  logic signed [n:0]     delta_q, delta_d;
  logic signed [n+k-1:0] acc_q, acc_d;
  logic                  underrun_q, underrun_d;

  logic                  consume;
  logic                  bufFull;
  logic        [n-1:0]   bufRaw;
  logic signed [n-1:0]   bufData;
  logic                  tick;

  dsmod_interp_buf #(.n(n)) u_buf (
    .clk_i     (clk),
    .rst_ni    (clr),
    .data_i    (in),
    .valid_i   (in_valid),
    .ready_o   (in_ready),
    .consume_i (consume),
    .data_o    (bufRaw),
    .full_o    (bufFull)
  );

  assign bufData  = $signed(bufRaw);
  assign tick     = (state_q == RUN) && (ph_q == k'(R - 1));
  assign out      = acc_q[n+k-1:k];
  assign underrun = underrun_q;

  // Tick reloads acc exactly from cur so truncation error never accumulates.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    prev_d     = prev_q;
    cur_d      = cur_q;
    delta_d    = delta_q;
    acc_d      = acc_q;
    underrun_d = 1'b0;
    consume    = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        ph_d  = '0;
        if (bufFull) begin
          prev_d  = '0;
          cur_d   = bufData;
          delta_d = (n+1)'(bufData);
          consume = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          acc_d  = $signed({cur_q, {k{1'b0}}});
          ph_d   = '0;
          prev_d = cur_q;
          if (bufFull) begin
            cur_d   = bufData;
            delta_d = (n+1)'(bufData) - (n+1)'(cur_q);
            consume = 1'b1;
          end else begin
            delta_d    = '0;
            underrun_d = 1'b1;
          end
        end else begin
          acc_d = acc_q + (n+k)'(delta_q);
          ph_d  = ph_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      prev_q     <= '0;
      cur_q      <= '0;
      delta_q    <= '0;
      acc_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      prev_q     <= prev_d;
      cur_q      <= cur_d;
      delta_q    <= delta_d;
      acc_q      <= acc_d;
      underrun_q <= underrun_d;
    end
  end

  // The slope register must always equal the span of the current ramp.
  assert property (@(posedge clk) disable iff (!clr)
    delta_q == (n+1)'(cur_q) - (n+1)'(prev_q));

endmodule

// File: tb/tb_dsmod_interp.sv
// Directed bench for dsmod_interp with n = 16, k = 2 (R = 4).
module tb_dsmod_interp;

  logic               clk;
  logic               clr;
  logic signed [15:0] inData;
  logic               inValid;
  logic               inReady;
  logic signed [15:0] outData;
  logic               underrunFlag;

  int checks;
  int errors;

  dsmod_interp #(.n(16), .k(2)) dut (
    .clk      (clk),
    .clr      (clr),
    .in       (inData),
    .in_valid (inValid),
    .in_ready (inReady),
    .out      (outData),
    .underrun (underrunFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b0;
    inData = '0;
    inValid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outData !== 16'sd0) begin
      errors++;
      $display("[TB] FAIL reset_out: got %0d expected 0", outData);
    end
    checks++;
    if (inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b expected 1", inReady);
    end
    checks++;
    if (underrunFlag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_underrun: got %b expected 0", underrunFlag);
    end
    clr = 1'b1;
  endtask

  task automatic test_ramp();
    int expRamp[4] = '{100, 200, 300, 400};
    inData = 16'sd400;
    inValid = 1'b1;
    stepCycle();
    inValid = 1'b0;
    checks++;
    if (inReady !== 1'b0 || outData !== 16'sd0) begin
      errors++;
      $display("[TB] FAIL ramp_accept: ready=%b out=%0d expected ready=0 out=0", inReady, outData);
    end
    stepCycle();
    checks++;
    if (inReady !== 1'b1 || outData !== 16'sd0) begin
      errors++;
      $display("[TB] FAIL ramp_start: ready=%b out=%0d expected ready=1 out=0", inReady, outData);
    end
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checks++;
      if (outData !== expRamp[i]) begin
        errors++;
        $display("[TB] FAIL ramp_step%0d: got %0d expected %0d", i, outData, expRamp[i]);
      end
    end
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) stepCycle();
      checks++;
      if (underrunFlag !== (i % 4 == 0) || outData !== 16'sd400) begin
        errors++;
        $display("[TB] FAIL underrun_cyc%0d: underrun=%b out=%0d expected underrun=%0d out=400",
                 i, underrunFlag, outData, (i % 4 == 0));
      end
    end
  endtask

  task automatic test_step_down();
    int expDown[5] = '{400, 200, 0, -200, -400};
    inData = -16'sd400;
    inValid = 1'b1;
    stepCycle();
    inValid = 1'b0;
    checks++;
    if (inReady !== 1'b0 || outData !== 16'sd400) begin
      errors++;
      $display("[TB] FAIL down_accept: ready=%b out=%0d expected ready=0 out=400", inReady, outData);
    end
    for (int i = 0; i < 2; i++) begin
      stepCycle();
      checks++;
      if (outData !== 16'sd400) begin
        errors++;
        $display("[TB] FAIL down_hold%0d: got %0d expected 400", i, outData);
      end
    end
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checks++;
      if (outData !== expDown[i]) begin
        errors++;
        $display("[TB] FAIL down_step%0d: got %0d expected %0d", i, outData, expDown[i]);
      end
    end
  endtask

  task automatic test_full_scale();
    int expFs[5] = '{32767, 16383, -1, -16385, -32768};
    inData = 16'sd32767;
    inValid = 1'b1;
    stepCycle();
    inValid = 1'b0;
    repeat (3) stepCycle();
    inData = -16'sd32768;
    inValid = 1'b1;
    stepCycle();
    inValid = 1'b0;
    repeat (2) stepCycle();
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checks++;
      if (outData !== expFs[i]) begin
        errors++;
        $display("[TB] FAIL fullscale_step%0d: got %0d expected %0d", i, outData, expFs[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int samples[3] = '{10, 20, 30};
    int expWait[3] = '{0, 3, 3};
    int expTail[5] = '{20, 22, 25, 27, 30};
    int waitCount;
    for (int s = 0; s < 3; s++) begin
      inData = 16'(samples[s]);
      inValid = 1'b1;
      waitCount = 0;
      while (!inReady && waitCount < 10) begin
        stepCycle();
        waitCount++;
      end
      checks++;
      if (inReady !== 1'b1 || waitCount != expWait[s]) begin
        errors++;
        $display("[TB] FAIL b2b_ready%0d: ready=%b waited=%0d expected ready=1 waited=%0d",
                 s, inReady, waitCount, expWait[s]);
      end
      stepCycle();
      checks++;
      if (inReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_drop%0d: ready=%b expected 0", s, inReady);
      end
    end
    inValid = 1'b0;
    repeat (2) stepCycle();
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checks++;
      if (outData !== expTail[i]) begin
        errors++;
        $display("[TB] FAIL b2b_tail%0d: got %0d expected %0d", i, outData, expTail[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checks++;
      if (outData !== 16'sd30) begin
        errors++;
        $display("[TB] FAIL b2b_hold%0d: got %0d expected 30", i, outData);
      end
    end
  endtask

  task automatic test_reset_mid();
    int expNew[5] = '{0, 2, 4, 6, 8};
    inData = 16'sd50;
    inValid = 1'b1;
    stepCycle();
    inValid = 1'b0;
    repeat (3) stepCycle();
    inData = 16'sd70;
    inValid = 1'b1;
    stepCycle();
    inValid = 1'b0;
    stepCycle();
    checks++;
    if (outData !== 16'sd40) begin
      errors++;
      $display("[TB] FAIL mid_before: got %0d expected 40", outData);
    end
    #2 clr = 1'b0;
    #1;
    checks++;
    if (outData !== 16'sd0 || inReady !== 1'b1 || underrunFlag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_async: out=%0d ready=%b underrun=%b expected 0/1/0",
               outData, inReady, underrunFlag);
    end
    repeat (2) @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checks++;
      if (outData !== 16'sd0 || inReady !== 1'b1 || underrunFlag !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mid_idle%0d: out=%0d ready=%b underrun=%b expected 0/1/0",
                 i, outData, inReady, underrunFlag);
      end
    end
    inData = 16'sd8;
    inValid = 1'b1;
    stepCycle();
    inValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checks++;
      if (outData !== expNew[i]) begin
        errors++;
        $display("[TB] FAIL mid_restart%0d: got %0d expected %0d", i, outData, expNew[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ramp();
    test_underrun();
    test_step_down();
    test_full_scale();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsmod_interp.md
Name: dsmod_interp

Overview:
Linear interpolator that sits directly upstream of the second-order delta-sigma modulator. It accepts signed samples at a low rate through a valid/ready handshake. It produces one linearly interpolated signed sample on every clock, ramping between consecutive input samples over R = 2^k clocks. Its output drives the modulator's data input directly on the same clock.

Parameters:
n, 16, bit width of input and output samples (signed)
k, 6, log2 of interpolation ratio; R = 2^k output clocks per input sample; k >= 1

Ports:
clk  input  1  sampling clock, shared with the modulator
clr  input  1  reset, asynchronous, active-low; all state is cleared while clr = 0
in  input  n  input sample, signed
in_valid  input  1  in holds a valid sample
in_ready  output  1  block can accept a sample this cycle
out  output  n  interpolated sample, signed, new value every clock
underrun  output  1  one-cycle pulse: a period boundary was reached with no buffered sample

Behaviour:
- Reset (clr = 0): state = IDLE, buffer empty, ph = 0, prev = 0, cur = 0, delta = 0, acc = 0; out = 0, in_ready = 1, underrun = 0. Handshakes while clr = 0 are ignored.
- Registers:
  - buf[n] with buf_full flag (one-entry input buffer)
  - prev[n] and cur[n] (signed)
  - delta[n+1] = cur - prev
  - acc[n+k] signed, holds the scaled output
  - ph[k] phase counter
- in_ready = !buf_full (combinational, from a register only).
- Accept: on a rising edge with in_valid && in_ready, buf <= in and buf_full <= 1.
- A sample cannot be accepted and consumed in the same cycle.
- out = acc >> k, arithmetic, i.e. acc[n+k-1:k]. Zero combinational latency from acc.
- tick = (state == RUN) && (ph == R-1).
- State IDLE:
  - acc held at 0, so out = 0; ph held at 0.
  - When buf_full: prev <= 0, cur <= buf, delta <= buf, acc <= 0, ph <= 0, buf_full <= 0, go to RUN.
  - The ramp therefore starts from 0.
- State RUN, non-tick cycle: acc <= acc + sign_extend(delta); ph <= ph + 1.
- State RUN, tick cycle (ph == R-1):
  - acc <= cur << k. This is an exact reload, so rounding drift cannot accumulate. ph <= 0.
  - If buf_full: prev <= cur, cur <= buf, delta <= buf - cur, buf_full <= 0.
  - Else (starved): prev <= cur, delta <= 0, underrun <= 1 for the next cycle only. out then holds cur until data arrives.
- RUN never returns to IDLE except through reset.
- Width rule: acc is always between prev<<k and cur<<k, so n+k bits never overflow. delta needs n+1 bits to cover full-scale swings.
- Latency: a sample accepted during period p becomes cur at the end of p. out equals that sample exactly R clocks after that tick.
- Reset mid-operation: all state is dropped immediately (asynchronous). After release the block restarts in IDLE with a ramp from 0. A buffered sample is lost.
- in_valid may drop without being accepted; no other protocol requirement applies to the upstream side.

Decomposition:
- No shared package needed.
- IDLE/RUN encoding and R = 1<<k are localparams inside the module.
- The accumulator stays inline. It is not the existing integrator, because it needs a parallel load.
- One sub-module is natural: dsmod_interp_buf, the one-entry valid/ready input buffer (buf, buf_full, in_ready, consume strobe). It is reusable by other low-rate feeders.

Test Plan:
(All with n = 16, k = 2, R = 4.)
1. Reset, then present 400 with in_valid. Required: accept on the first edge; out = 0, 100, 200, 300 over the four RUN clocks, then 400.
2. From a steady 400, present -400 before the tick. Required: out = 400, 200, 0, -200, then -400 on the following tick.
3. No sample offered after 400 reaches cur. Required: underrun pulses high for exactly 1 cycle after the tick; out holds 400 each period; underrun repeats each starved period.
4. Present 32767, then -32768. Required: out = 32767, 16383, -1, -16385, then -32768. No wrap or overflow.
5. in_valid held high with samples 10, 20, 30 streamed. Required: in_ready drops after each accept and rises the cycle after each tick consumes buf; no sample is dropped or duplicated.
6. Drive clr low mid-ramp (ph = 2). Required: out = 0, in_ready = 1, underrun = 0 immediately, without waiting for a clock. After release, the block waits in IDLE with out = 0 until a new sample arrives.
